// File: rtl/data_mem_responder_if.sv
// Data-memory port between the processor datapath (master) and the
// multi-cycle responder (slave): request fields plus the stall/done reply.
interface data_mem_responder_if;
  logic        req_en;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        stall;
  logic        done;
  logic [15:0] rdata;
  logic        err;

  modport master (
    output req_en, req_wr, req_addr, req_wdata,
    input  stall, done, rdata, err
  );

  modport slave (
    input  req_en, req_wr, req_addr, req_wdata,
    output stall, done, rdata, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one word read or write over an
// enable/stall/done handshake, holds it for LATENCY cycles, then commits the
// write or returns the read data. Misaligned or out-of-range requests take
// the same time but complete with err=1 and rdata=0 and never touch storage.
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_responder_if.slave bus
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // A request is illegal when it is not word aligned or when its word index
  // does not fit in the array (any byte-address bit above DEPTH_LOG2 set).
  function automatic logic f_illegal(input logic [15:0] a);
    return a[0] | ((a >> (DEPTH_LOG2 + 1)) != 16'd0);
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;

  logic                  r_wr;
  logic [15:0]           r_addr;
  logic [15:0]           r_wdata;

  logic                  r_stall;
  logic                  r_done;
  logic                  r_err;
  logic [15:0]           r_rdata;

  logic [15:0]           r_mem [0:WORDS-1];

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_cur_wr;
  logic [15:0]           w_cur_addr;
  logic [15:0]           w_cur_wdata;
  logic                  w_illegal;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_mem_we;
  logic                  w_stall_nxt;
  logic                  w_done_nxt;
  logic                  w_err_nxt;
  logic [15:0]           w_rdata_nxt;

  // stall is registered and equals "in BUSY", so it is the accept gate
  assign w_accept = bus.req_en & ~r_stall;

  // With a one-cycle latency the request commits on its own accept edge,
  // before the latch holds it, so the live inputs are used directly.
  assign w_cur_wr    = (LATENCY == 1) ? bus.req_wr    : r_wr;
  assign w_cur_addr  = (LATENCY == 1) ? bus.req_addr  : r_addr;
  assign w_cur_wdata = (LATENCY == 1) ? bus.req_wdata : r_wdata;

  assign w_illegal = f_illegal(w_cur_addr);
  assign w_idx     = w_cur_addr[DEPTH_LOG2:1];

  // Commit edge: leaving BUSY after the last hold cycle, or the accept
  // itself when there is no BUSY phase at all.
  assign w_commit = (LATENCY == 1) ? w_accept
                                   : ((r_state == S_BUSY) && (r_cnt == 4'd1));

  // rst gates the store so a request caught by reset can never land
  assign w_mem_we = w_commit & w_cur_wr & ~w_illegal & rst;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: BUSY is skipped entirely when LATENCY is 1
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          w_state_nxt = (LATENCY > 1) ? S_BUSY : S_RESP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered handshake and read data
  always_comb begin
    w_stall_nxt = (w_state_nxt == S_BUSY);
    w_done_nxt  = (w_state_nxt == S_RESP);
    w_err_nxt   = w_commit & w_illegal;
    w_rdata_nxt = r_rdata;
    if (w_commit) begin
      if (w_illegal) begin
        w_rdata_nxt = 16'h0000;
      end else if (!w_cur_wr) begin
        w_rdata_nxt = r_mem[w_idx];
      end
    end
  end

  // Registered outputs, cleared by reset so a discarded request yields no done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 16'h0000;
    end else begin
      r_stall <= w_stall_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  // Latency counter: loaded with LATENCY-1 on accept, counts down in BUSY
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 4'd0;
    end else if (w_accept && (r_state != S_BUSY)) begin
      r_cnt <= 4'(LATENCY - 1);
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Request latch: data only, meaningful solely while a request is held
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wr    <= bus.req_wr;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
    end
  end

  // Word storage: not reset, written only by a legal write commit
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= w_cur_wdata;
    end
  end

  assign bus.stall = r_stall;
  assign bus.done  = r_done;
  assign bus.err   = r_err;
  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=4 instance driven from a request
// table plus a reset-abort sequence, and a LATENCY=1 instance for the
// back-to-back boundary. Expected completions are queued at accept time and
// checked against each done pulse (cycle, err, rdata).
module tb_data_mem_responder;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;
  bit   stall1_seen;

  data_mem_responder_if if4 ();
  data_mem_responder_if if1 ();

  data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          xerr;
    logic [15:0] xrd;
  } vec_t;

  typedef struct {
    int          cyc;
    bit          err;
    logic [15:0] rdata;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] xp);
    tests++;
    if (act !== xp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, xp, cyc);
    end
  endfunction

  function automatic bit stall_of(input int sel);
    return (sel == 0) ? if4.stall : if1.stall;
  endfunction

  task automatic drive(input int sel, input bit en, input bit wr,
                       input logic [15:0] a, input logic [15:0] d);
    if (sel == 0) begin
      if4.req_en = en; if4.req_wr = wr; if4.req_addr = a; if4.req_wdata = d;
    end else begin
      if1.req_en = en; if1.req_wr = wr; if1.req_addr = a; if1.req_wdata = d;
    end
  endtask

  // Present a request while stall is low, queue its expected completion,
  // then wait out the stall; returns in the done cycle so the next call
  // is accepted back-to-back.
  task automatic issue(input int sel, input bit wr, input logic [15:0] a,
                       input logic [15:0] d, input bit xerr, input logic [15:0] xrd);
    exp_t e;
    int   n;
    int   lat;
    lat = (sel == 0) ? 4 : 1;
    drive(sel, 1'b1, wr, a, d);
    @(posedge clk); #1;
    e.cyc = cyc + lat - 1;
    e.err = xerr;
    e.rdata = xrd;
    if (sel == 0) q4.push_back(e); else q1.push_back(e);
    drive(sel, 1'b0, wr, a, d);
    n = 0;
    while (stall_of(sel) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("stall_cycles[%0d]@%h", sel, a), n, lat - 1);
  endtask

  // Completion monitor for the LATENCY=4 instance
  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst && if4.err && !if4.done) chk("err_without_done4", {31'd0, if4.err}, 32'd0);
    if (rst && if4.done) begin
      if (q4.size() == 0) begin
        chk("unexpected_done4", 32'd1, 32'd0);
      end else begin
        e = q4.pop_front();
        chk("done_cycle4", cyc, e.cyc);
        chk("err4", {31'd0, if4.err}, {31'd0, e.err});
        chk("rdata4", {16'd0, if4.rdata}, {16'd0, e.rdata});
      end
    end
  end

  // Completion monitor for the LATENCY=1 instance
  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst && if1.stall) stall1_seen = 1'b1;
    if (rst && if1.done) begin
      if (q1.size() == 0) begin
        chk("unexpected_done1", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("done_cycle1", cyc, e.cyc);
        chk("err1", {31'd0, if1.err}, {31'd0, e.err});
        chk("rdata1", {16'd0, if1.rdata}, {16'd0, e.rdata});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[15];
    vec_t t1[5];

    tbl[0]  = '{1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
    tbl[2]  = '{1'b1, 16'h0020, 16'h1234, 1'b0, 16'hBEEF};
    tbl[3]  = '{1'b0, 16'h0020, 16'h0000, 1'b0, 16'h1234};
    tbl[4]  = '{1'b1, 16'h0011, 16'hFFFF, 1'b1, 16'h0000};
    tbl[5]  = '{1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
    tbl[6]  = '{1'b0, 16'h0800, 16'h0000, 1'b1, 16'h0000};
    tbl[7]  = '{1'b1, 16'h07FE, 16'h0F0F, 1'b0, 16'h0000};
    tbl[8]  = '{1'b0, 16'h07FE, 16'h0000, 1'b0, 16'h0F0F};
    tbl[9]  = '{1'b1, 16'h0000, 16'h7777, 1'b0, 16'h0F0F};
    tbl[10] = '{1'b1, 16'h8000, 16'h1111, 1'b1, 16'h0000};
    tbl[11] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h7777};
    tbl[12] = '{1'b0, 16'hFFFE, 16'h0000, 1'b1, 16'h0000};
    tbl[13] = '{1'b1, 16'h0030, 16'h5555, 1'b0, 16'h0000};
    tbl[14] = '{1'b0, 16'h0030, 16'h0000, 1'b0, 16'h5555};

    t1[0] = '{1'b1, 16'h0002, 16'hA1A1, 1'b0, 16'h0000};
    t1[1] = '{1'b1, 16'h0004, 16'hB2B2, 1'b0, 16'h0000};
    t1[2] = '{1'b0, 16'h0002, 16'h0000, 1'b0, 16'hA1A1};
    t1[3] = '{1'b0, 16'h0004, 16'h0000, 1'b0, 16'hB2B2};
    t1[4] = '{1'b0, 16'h0003, 16'h0000, 1'b1, 16'h0000};

    tests = 0;
    fails = 0;
    cyc = 0;
    stall1_seen = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Reset values
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_stall4", {31'd0, if4.stall}, 32'd0);
    chk("rst_done4",  {31'd0, if4.done},  32'd0);
    chk("rst_err4",   {31'd0, if4.err},   32'd0);
    chk("rst_rdata4", {16'd0, if4.rdata}, 32'd0);
    chk("rst_done1",  {31'd0, if1.done},  32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Table of back-to-back requests on the LATENCY=4 instance
    for (int i = 0; i < 15; i++) begin
      issue(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].xerr, tbl[i].xrd);
    end

    // Reset in cycle 2 of a write of 0xAAAA over 0x5555 at 0x0030
    drive(0, 1'b1, 1'b1, 16'h0030, 16'hAAAA);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 16'h0030, 16'hAAAA);
    @(posedge clk); #1;
    chk("abort_stall_before", {31'd0, if4.stall}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_stall", {31'd0, if4.stall}, 32'd0);
    chk("abort_done",  {31'd0, if4.done},  32'd0);
    chk("abort_err",   {31'd0, if4.err},   32'd0);
    chk("abort_rdata", {16'd0, if4.rdata}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_pending", q4.size(), 32'd0);
    issue(0, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h5555);
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // LATENCY=1: consecutive accepts, done one cycle after each
    for (int i = 0; i < 5; i++) begin
      issue(1, t1[i].wr, t1[i].addr, t1[i].wdata, t1[i].xerr, t1[i].xrd);
    end
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);

    repeat (6) @(posedge clk);
    #1;
    chk("drain_q4", q4.size(), 32'd0);
    chk("drain_q1", q1.size(), 32'd0);
    chk("lat1_never_stalls", {31'd0, stall1_seen}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle responder for the processor's data-memory port: it accepts one word read or write at a time over an enable/stall/done handshake, holds it for a programmable latency, then commits the write or returns the read data. It stands in place of the single-cycle data memory, so the datapath can be exercised against realistic memory stalls. Storage is an internal word array; alignment and range violations are reported, not executed.

## Interface
- `DEPTH_LOG2`, default 10: log2 of word count; 1024 words, byte addresses 0x0000–0x07FE.
- `LATENCY`, default 4: cycles from accept to `done`; legal range 1–15.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_en`  in  1  request valid.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_addr`  in  16  byte address; word index = `req_addr[DEPTH_LOG2:1]`.
- `req_wdata`  in  16  write data.
- `stall`  out  1  responder busy; `req_en` is ignored while high.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  16  read result, valid in the `done` cycle of a read.
- `err`  out  1  asserted with `done` when the request was illegal.

## Operation
- States: IDLE, BUSY, RESP.
- Accept: `req_en`=1 and `stall`=0 at a rising edge. Latch `req_wr`, `req_addr`, `req_wdata`, and load the latency counter.
- IDLE: `stall`=0, `done`=0. On accept, go to BUSY if `LATENCY`>1; otherwise go to RESP.
- BUSY: `stall`=1 and the counter decrements. When the request has been held for `LATENCY`-1 cycles, go to RESP. On that same edge:
  - a legal write updates the array;
  - a legal read registers array data into `rdata`.
- RESP: `done`=1, `stall`=0. Accept in RESP starts the next request (back-to-back); otherwise return to IDLE.
- Illegal request: `addr[0]`=1 (misaligned), or `addr[15:1]` ≥ 2^`DEPTH_LOG2` (out of range).
  - Same latency as a legal request.
  - No array write.
  - `rdata` forced to 0.
  - `err`=1 for the `done` cycle only.
- `rdata` changes only on a legal read completion or an illegal completion (forced to 0). It holds otherwise, including through write completions.
- A read issued immediately after a write to the same word returns the new data.
- Array contents are not cleared by reset and are undefined after power-up.

## Timing
- Reset (async assert): state IDLE, `stall`=0, `done`=0, `err`=0, `rdata`=0, counter=0.
- Reset asserted mid-operation: the pending request is discarded and any uncommitted write is lost. `done` is never produced for it.
- Request presented in cycle 0 and accepted at the end of cycle 0:
  - `stall`=1 in cycles 1..`LATENCY`-1;
  - `done`=1 in cycle `LATENCY`.
- Throughput: with back-to-back accepts in RESP, one request completes every `LATENCY` cycles.
- `LATENCY`=1: `stall` is never asserted, and `done` follows each accept by one cycle.
- The initiator must hold `req_*` stable until it sees `stall`=0. Values presented during BUSY are don't-care.
- `done`, `err`, `rdata` and `stall` are all registered outputs. There is no combinational path from inputs to outputs.

## Test plan
- Reset values and timing (`LATENCY`=4): release `rst`; write 0xBEEF to 0x0010 in cycle 0.
  - Required: `stall`=1 in cycles 1–3, `done`=1 with `err`=0 in cycle 4.
  - Then read 0x0010: `rdata`=0xBEEF in its `done` cycle.
- Back-to-back: in the RESP cycle, accept a read of the word just written (0x0020 ← 0x1234). `rdata`=0x1234 four cycles later, with no idle cycle between the two requests.
- Misaligned write to 0x0011 with data 0xFFFF:
  - `done`=1, `err`=1, `rdata`=0 in cycle 4.
  - A subsequent read of 0x0010 returns the prior contents unchanged.
- Out-of-range read of 0x0800 (`DEPTH_LOG2`=10): `err`=1 and `rdata`=0 in the `done` cycle. A read of 0x07FE completes with `err`=0.
- Reset in cycle 2 of a write of 0xAAAA to 0x0030 (array pre-loaded with 0x5555 there):
  - all outputs return to reset values;
  - no `done` is produced;
  - a later read of 0x0030 returns 0x5555.
- Boundary latency with `LATENCY`=1: three consecutive accepted reads. `stall` stays 0 throughout, and each `done` falls exactly one cycle after its accept.
